// File: rtl/da_lms_pkg.sv
// Shared constants and types for the 16-tap DA-LMS filter datapath.
package da_lms_pkg;

  localparam int NTAPS = 16;
  localparam int GRP   = 4;
  localparam int NGRP  = NTAPS / GRP;
  localparam int XW    = 8;
  localparam int WW    = 8;
  localparam int YW    = 20;
  localparam int LUTW  = 10;
  localparam int SW    = 12;

  localparam logic [3:0] E_LAST = 4'd15;
  localparam logic [3:0] B_MSB  = 4'd7;

  typedef enum logic [1:0] {IDLE, FILL, ACC} state_e;

  // Bit offset of tap k in a bus of w-bit lanes.
  function automatic int tap_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/da_lut_group.sv
// Weight-combination LUT for one group of 4 taps: entry e = sum of weights selected by e.
module da_lut_group
  import da_lms_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [3:0]             e,
  input  logic [GRP*WW-1:0]      w,
  input  logic [3:0]             addr,
  output logic signed [LUTW-1:0] q
);

  logic signed [LUTW-1:0] mem [16];
  logic signed [LUTW-1:0] fill_val;

  always_comb begin
    fill_val = '0;
    for (int unsigned i = 0; i < GRP; i++) begin
      if (e[i]) fill_val = fill_val + LUTW'($signed(w[tap_lsb(int'(i), WW) +: WW]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < 16; j++) mem[j] <= '0;
    end else if (we) begin
      mem[e] <= fill_val;
    end
  end

  assign q = mem[addr];

endmodule

// File: rtl/da_inner_product.sv
// Bit-serial distributed-arithmetic inner product y = sum(w_k * x_k), 16 taps.
module da_inner_product #(
  parameter int XW = 8,
  parameter int WW = 8,
  parameter int YW = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [16*XW-1:0]   x_bus,
  input  logic [16*WW-1:0]   w_bus,
  output logic               busy,
  output logic               done,
  output logic [YW-1:0]      y
);
  import da_lms_pkg::*;

  state_e                 state, state_nxt;
  logic [3:0]             cnt;
  logic [16*XW-1:0]       x_reg;
  logic [16*WW-1:0]       w_reg;
  logic signed [YW-1:0]   acc, acc_nxt, s_ext;
  logic signed [SW-1:0]   s_sum;
  logic signed [LUTW-1:0] lut_q [NGRP];
  logic [3:0]             addr  [NGRP];
  logic                   fill_we;

  assign fill_we = (state == FILL);

  for (genvar g = 0; g < NGRP; g++) begin : g_lut
    da_lut_group u_lut (
      .clk  (clk),
      .rst  (rst),
      .we   (fill_we),
      .e    (cnt),
      .w    (w_reg[g*GRP*WW +: GRP*WW]),
      .addr (addr[g]),
      .q    (lut_q[g])
    );
  end

  // In ACC the low 3 bits of cnt select the sample bit being consumed.
  always_comb begin
    for (int unsigned g = 0; g < NGRP; g++) begin
      addr[g] = '0;
      for (int unsigned i = 0; i < GRP; i++) begin
        addr[g][i] = x_reg[tap_lsb(int'(GRP*g + i), XW) + int'(cnt[2:0])];
      end
    end
  end

  always_comb begin
    s_sum = '0;
    for (int unsigned g = 0; g < NGRP; g++) s_sum = s_sum + SW'(lut_q[g]);
    s_ext   = YW'(s_sum);
    acc_nxt = (cnt == B_MSB) ? -s_ext : (acc <<< 1) + s_ext;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (cnt == E_LAST) state_nxt = ACC;
      ACC:     if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      x_reg <= '0;
      w_reg <= '0;
      acc   <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= x_bus;
            w_reg <= w_bus;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        FILL: cnt <= (cnt == E_LAST) ? B_MSB : cnt + 4'd1;
        ACC: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            y    <= acc_nxt;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_da_inner_product.sv
// Scoreboard bench for da_inner_product: expected y queued at start, checked on done.
module tb_da_inner_product;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] x_bus;
  logic [127:0] w_bus;
  logic         busy;
  logic         done;
  logic [19:0]  y;

  int n_checks;
  int n_fail;
  int sb[$];

  da_inner_product #(.XW(8), .WW(8), .YW(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_bus (x_bus),
    .w_bus (w_bus),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input logic [127:0] x, input logic [127:0] w);
    int s = 0;
    for (int k = 0; k < 16; k++)
      s += int'($signed(x[8*k +: 8])) * int'($signed(w[8*k +: 8]));
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("extra_done", int'(done), 0);
      else chk("y", 32'($signed(y)), sb.pop_front());
      chk("busy_done_excl", int'(busy), 0);
    end
  end

  task automatic do_run(input logic [127:0] x, input logic [127:0] w, input int exp,
                        input bit toggle, input int pulse_at);
    int  busy_cyc;
    bit  seen;
    @(negedge clk);
    x_bus = x; w_bus = w; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    busy_cyc = int'(busy);
    seen = 1'b0;
    if (toggle) begin
      x_bus = rand128();
      w_bus = rand128();
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == pulse_at);
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        chk("latency", n, 24);
        chk("busy_cycles", busy_cyc, 24);
        break;
      end
      busy_cyc += int'(busy);
    end
    start = 1'b0;
    chk("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    chk("done_fall", int'(done), 0);
  endtask

  initial begin
    logic [127:0] xv, wv, xa, wa, xb, wb, xc, wc;
    int ndone, last, yhold;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; start = 1'b0; x_bus = '0; w_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_y", 32'($signed(y)), 0);
    @(negedge clk) rst = 1'b1;

    // 1: all ones
    do_run({16{8'h01}}, {16{8'h01}}, 16, 1'b0, 0);

    // 2: x_k = k, w = +1 then -1
    for (int k = 0; k < 16; k++) xv[8*k +: 8] = 8'(k);
    do_run(xv, {16{8'h01}}, 120, 1'b0, 0);
    do_run(xv, {16{8'hFF}}, -120, 1'b0, 0);

    // 3: extremes
    do_run({16{8'h80}}, {16{8'h80}}, 262144, 1'b0, 0);
    do_run({16{8'h80}}, {16{8'h7F}}, -260096, 1'b0, 0);

    // 4: random with bus toggling after acceptance
    for (int r = 0; r < 1000; r++) begin
      xv = rand128();
      wv = rand128();
      do_run(xv, wv, model(xv, wv), 1'b1, 0);
    end

    // 5a: start pulsed in FILL is ignored
    xv = rand128(); wv = rand128();
    do_run(xv, wv, model(xv, wv), 1'b0, 5);
    repeat (30) @(posedge clk);

    // 5b: reset during ACC aborts the run
    @(negedge clk);
    x_bus = rand128(); w_bus = rand128(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_y", 32'($signed(y)), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("post_abort_idle", int'(busy), 0);
    xv = rand128(); wv = rand128();
    do_run(xv, wv, model(xv, wv), 1'b0, 0);

    // 6: start held high for three back-to-back runs
    xa = rand128(); wa = rand128();
    xb = rand128(); wb = rand128();
    xc = rand128(); wc = rand128();
    @(negedge clk);
    x_bus = xa; w_bus = wa; start = 1'b1;
    sb.push_back(model(xa, wa));
    sb.push_back(model(xb, wb));
    sb.push_back(model(xc, wc));
    @(posedge clk); #1;
    x_bus = xb; w_bus = wb;
    ndone = 0; last = 0; yhold = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 26) begin
        x_bus = xc; w_bus = wc;
      end
      if (done) begin
        if (ndone == 0) chk("held_first", c, 24);
        else chk("held_period", c - last, 25);
        last  = c;
        yhold = 32'($signed(y));
        ndone++;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end else if (ndone > 0) begin
        chk("y_hold", 32'($signed(y)), yhold);
      end
    end
    start = 1'b0;
    chk("held_dones", ndone, 3);
    repeat (30) @(posedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/da_inner_product.md
Name: da_inner_product

Overview:
Distributed-arithmetic (DA) inner-product engine for the 16-tap DA-LMS adaptive filter. It sits directly downstream of the 16-sample input capture stage and computes y = sum(w_k * x_k) for k = 0..15.
- Bit-serial over the sample bits.
- Per-group weight-combination LUTs (4 groups of 4 taps).
- y feeds the error/weight-update stage.

Parameters:
XW, 8, sample width (signed two's complement); only 8 supported
WW, 8, weight width (signed); only 8 supported
YW, 20, output width; must be >= XW+WW+4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  request a computation; sampled only in IDLE
x_bus  in  16*XW  tap samples; x_k at bits [XW*k+XW-1 : XW*k]
w_bus  in  16*WW  weights; w_k at bits [WW*k+WW-1 : WW*k]
busy  out  1  high while a computation is in progress
done  out  1  one-cycle pulse: y valid
y  out  YW  signed result; held until the next done

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, y=0, accumulator=0, all LUT entries=0, counters=0.
- States:
  - IDLE
  - FILL (16 cycles)
  - ACC (8 cycles)
  - Transitions: IDLE -> FILL -> ACC -> IDLE.
- IDLE, start=1 at an edge:
  - Latch x_bus and w_bus into internal registers.
  - Set busy=1, e=0, go to FILL.
  - Later changes on x_bus/w_bus do not affect the run.
- FILL, one entry per edge, e = 0..15:
  - Each group g (taps 4g..4g+3) writes LUT_g[e] = sum of w_(4g+i) over the set bits i of e.
  - Entries are 10-bit signed; LUT_g[0] = 0.
  - After e = 15: go to ACC with b = 7.
- ACC, one bit per edge, MSB first, b = 7..0:
  - addr_g = {x_(4g+3)[b], x_(4g+2)[b], x_(4g+1)[b], x_(4g)[b]}.
  - S_b = sum over g of LUT_g[addr_g], 12-bit signed.
  - b = 7: acc <= -S_7 (sign-bit weight).
  - b < 7: acc <= 2*acc + S_b.
  - All arithmetic is sign-extended to YW. No saturation is needed: range is [-260096, 262144].
- At the b = 0 edge: y <= final acc, done <= 1, busy <= 0, go to IDLE.
  - done falls at the next edge.
- Latency: done is high in the cycle after the 24th rising edge following the accepting edge.
  - Run period with start held high is 25 cycles; start is re-accepted on the edge that ends the done cycle.
- start while busy=1: ignored; no queuing.
- Reset asserted mid-run: run aborted, outputs return to reset values, no done pulse.
  - The first start after rst deasserts begins a clean run.
- busy and done are never high in the same cycle.

Decomposition:
- Shared package da_lms_pkg:
  - NTAPS=16, GRP=4, NGRP=4, XW, WW, YW, LUTW=10.
  - State enum {IDLE, FILL, ACC}.
  - Tap slice helper constants.
- Sub-module da_lut_group, instantiated 4 times:
  - 16x10-bit LUT register file.
  - Fill port: e plus 4 weights.
  - Read port: 4-bit address -> entry, combinational.
  - Same clk/rst.
- The top level holds the FSM, counters, operand registers, adder of the 4 LUT outputs, and the accumulator.

Test Plan:
1. All x_k=1, all w_k=1, start pulse -> done exactly 24 edges after the accepting edge, y=16, busy high for exactly 24 cycles.
2. x_k=k (0..15), w_k=1 -> y=120; then w_k=-1 with the same x -> y=-120.
3. Extremes, all x_k=-128:
   - all w_k=-128 -> y=262144;
   - all w_k=127 -> y=-260096.
4. Random signed x/w (1000 runs) vs reference model -> exact match; x_bus/w_bus toggled during the run do not change y.
5. start pulsed at cycle 5 of FILL -> ignored, single done. rst asserted during ACC -> busy=0, done=0, y=0 immediately; no done for the aborted run; next start gives the correct result.
6. start held high for 3 runs -> done pulses spaced 25 cycles apart with the correct y each; y stable between pulses.
